// File: rtl/npu_sram_arbiter_if.sv
// Requester-side and SRAM-side bus bundle for npu_sram_arbiter.
// req_lock exists only when NPU_SRAM_ARB_BURST_EN is defined.
interface npu_sram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ*BE_W-1:0]   req_byteenable;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;
  logic [ADDR_W-1:0]         sram_address;
  logic                      sram_chipselect;
  logic                      sram_write;
  logic [DATA_W-1:0]         sram_writedata;
  logic [BE_W-1:0]           sram_byteenable;
  logic                      sram_clken;
  logic [DATA_W-1:0]         sram_readdata;

`ifdef NPU_SRAM_ARB_BURST_EN
  logic [NUM_REQ-1:0]        req_lock;

  modport slave (
    input  req_address, req_read, req_write, req_writedata, req_byteenable, req_lock,
           sram_readdata,
    output req_waitrequest, req_readdata, req_readdatavalid,
           sram_address, sram_chipselect, sram_write, sram_writedata, sram_byteenable,
           sram_clken
  );

  modport master (
    output req_address, req_read, req_write, req_writedata, req_byteenable, req_lock,
           sram_readdata,
    input  req_waitrequest, req_readdata, req_readdatavalid,
           sram_address, sram_chipselect, sram_write, sram_writedata, sram_byteenable,
           sram_clken
  );
`else
  modport slave (
    input  req_address, req_read, req_write, req_writedata, req_byteenable,
           sram_readdata,
    output req_waitrequest, req_readdata, req_readdatavalid,
           sram_address, sram_chipselect, sram_write, sram_writedata, sram_byteenable,
           sram_clken
  );

  modport master (
    output req_address, req_read, req_write, req_writedata, req_byteenable,
           sram_readdata,
    input  req_waitrequest, req_readdata, req_readdatavalid,
           sram_address, sram_chipselect, sram_write, sram_writedata, sram_byteenable,
           sram_clken
  );
`endif
endinterface

// File: rtl/npu_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM Avalon-MM port between NUM_REQ NPU masters.
// Optional burst locking is enabled by defining NPU_SRAM_ARB_BURST_EN.
module npu_sram_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16
`ifdef NPU_SRAM_ARB_BURST_EN
  , parameter int MAX_BURST = 8
`endif
) (
  input logic              clk,
  input logic              reset,
  npu_sram_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [ADDR_W-1:0] addr_slice [NUM_REQ];
  logic [DATA_W-1:0] data_slice [NUM_REQ];
  logic [BE_W-1:0]   be_slice   [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_slice[gi] = bus.req_address[gi*ADDR_W +: ADDR_W];
      assign data_slice[gi] = bus.req_writedata[gi*DATA_W +: DATA_W];
      assign be_slice[gi]   = bus.req_byteenable[gi*BE_W +: BE_W];
    end
  endgenerate

  logic [NUM_REQ-1:0] active;
  ptr_t               rr_ptr_reg;
  logic [NUM_REQ-1:0] rd_pending_reg;
  logic               rr_found;
  ptr_t               rr_idx;
  logic               grant_valid;
  ptr_t               grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               accept_read;

  assign active = bus.req_read | bus.req_write;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(NUM_REQ - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Search from rr_ptr upward, wrapping, for the first active requester.
  always_comb begin
    int idx;
    rr_found = 1'b0;
    rr_idx   = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_found && active[ptr_t'(idx)]) begin
        rr_found = 1'b1;
        rr_idx   = ptr_t'(idx);
      end
    end
  end

`ifdef NPU_SRAM_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic             locked_reg;
  ptr_t             lock_id_reg;
  logic [CNT_W-1:0] burst_cnt_reg;
  logic             lock_hit;
  logic             lock_release;

  // The lock owner jumps the queue until it drops lock, goes idle or uses up its burst.
  assign lock_hit     = locked_reg && bus.req_lock[lock_id_reg] && active[lock_id_reg]
                        && (burst_cnt_reg < MAX_CNT);
  assign lock_release = locked_reg && !lock_hit;
  assign grant_valid  = !reset && (lock_hit || rr_found);
  assign grant_idx    = lock_hit ? lock_id_reg : rr_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      locked_reg    <= 1'b0;
      lock_id_reg   <= '0;
      burst_cnt_reg <= '0;
    end else if (grant_valid && bus.req_lock[grant_idx]) begin
      locked_reg    <= 1'b1;
      lock_id_reg   <= grant_idx;
      burst_cnt_reg <= lock_hit ? burst_cnt_reg + 1'b1 : CNT_W'(1);
    end else if (lock_release) begin
      locked_reg    <= 1'b0;
      burst_cnt_reg <= '0;
    end
  end
`else
  assign grant_valid = !reset && rr_found;
  assign grant_idx   = rr_idx;
`endif

  always_comb begin
    grant_oh = '0;
    if (grant_valid) grant_oh[grant_idx] = 1'b1;
  end

  // A read issued together with a write is dropped: the write wins, no data returns.
  assign accept_read = grant_valid && bus.req_read[grant_idx] && !bus.req_write[grant_idx];

  assign bus.req_waitrequest   = ~grant_oh;
  assign bus.sram_chipselect   = grant_valid;
  assign bus.sram_write        = grant_valid && bus.req_write[grant_idx];
  assign bus.sram_address      = grant_valid ? addr_slice[grant_idx] : '0;
  assign bus.sram_writedata    = grant_valid ? data_slice[grant_idx] : '0;
  assign bus.sram_byteenable   = grant_valid ? be_slice[grant_idx]   : '0;
  assign bus.sram_clken        = 1'b1;
  assign bus.req_readdata      = bus.sram_readdata;
  assign bus.req_readdatavalid = reset ? '0 : rd_pending_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg     <= '0;
      rd_pending_reg <= '0;
    end else begin
      rd_pending_reg <= accept_read ? grant_oh : '0;
      if (grant_valid) begin
        rr_ptr_reg <= next_ptr(grant_idx);
      end
`ifdef NPU_SRAM_ARB_BURST_EN
      else if (lock_release) begin
        rr_ptr_reg <= next_ptr(lock_id_reg);
      end
`endif
    end
  end

endmodule

// File: tb/tb_npu_sram_arbiter.sv
// Scoreboard bench for npu_sram_arbiter with a behavioural 4096x16 SRAM model.
// Build with NPU_SRAM_ARB_BURST_EN defined to exercise the burst-lock sequence (MAX_BURST = 4).
module tb_npu_sram_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  npu_sram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  npu_sram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
`ifdef NPU_SRAM_ARB_BURST_EN
    , .MAX_BURST(4)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // SRAM model: registered read (1-cycle latency), byte-enabled write.
  logic [15:0] mem [4096];
  bit          written [4096];
  logic [15:0] q_reg;
  logic [15:0] cur_word;

  function automatic logic [15:0] init_word(input logic [11:0] a);
    case (a)
      12'h123: return 16'hBEEF;
      12'hFFF: return 16'h1234;
      12'h010: return 16'h1111;
      12'h011: return 16'h2222;
      12'h012: return 16'h3333;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.sram_chipselect) begin
      cur_word = written[bus.sram_address] ? mem[bus.sram_address] : init_word(bus.sram_address);
      if (bus.sram_write) begin
        if (bus.sram_byteenable[0]) cur_word[7:0]  = bus.sram_writedata[7:0];
        if (bus.sram_byteenable[1]) cur_word[15:8] = bus.sram_writedata[15:8];
        mem[bus.sram_address]     <= cur_word;
        written[bus.sram_address] <= 1'b1;
      end else begin
        q_reg <= cur_word;
      end
    end
  end
  assign bus.sram_readdata = q_reg;

  typedef struct { int idx; logic [11:0] addr; logic wr; } grant_t;
  typedef struct { logic [2:0] oh; logic [15:0] data; } rdv_t;

  grant_t gq[$];
  rdv_t   rq[$];
  int     checks = 0;
  int     errors = 0;

  grant_t     g_exp;
  rdv_t       r_exp;
  logic [2:0] wr_exp;

  // Monitor: every grant and every readdatavalid must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.req_waitrequest !== 3'b111) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: waitrequest=%b addr=%h, required no grant",
                 bus.req_waitrequest, bus.sram_address);
      end else begin
        g_exp  = gq.pop_front();
        wr_exp = ~(3'b001 << g_exp.idx);
        if (bus.req_waitrequest !== wr_exp || bus.sram_address !== g_exp.addr ||
            bus.sram_write !== g_exp.wr || bus.sram_chipselect !== 1'b1) begin
          errors++;
          $display("FAIL grant: waitreq=%b addr=%h wr=%b cs=%b, required waitreq=%b addr=%h wr=%b cs=1",
                   bus.req_waitrequest, bus.sram_address, bus.sram_write, bus.sram_chipselect,
                   wr_exp, g_exp.addr, g_exp.wr);
        end else begin
          $display("grant req=%0d addr=%h write=%b", g_exp.idx, g_exp.addr, g_exp.wr);
        end
      end
    end
    if (bus.req_readdatavalid !== 3'b000) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rdv_unexpected: readdatavalid=%b data=%h, required none",
                 bus.req_readdatavalid, bus.req_readdata);
      end else begin
        r_exp = rq.pop_front();
        if (bus.req_readdatavalid !== r_exp.oh || bus.req_readdata !== r_exp.data) begin
          errors++;
          $display("FAIL readdata: valid=%b data=%h, required valid=%b data=%h",
                   bus.req_readdatavalid, bus.req_readdata, r_exp.oh, r_exp.data);
        end else begin
          $display("readdata valid=%b data=%h", r_exp.oh, r_exp.data);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [11:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    bus.req_address[i*12 +: 12]  = a;
    bus.req_writedata[i*16 +: 16] = d;
    bus.req_byteenable[i*2 +: 2] = be;
  endtask

  task automatic exp_grant(input int idx, input logic [11:0] a, input logic wr);
    grant_t t;
    t.idx = idx; t.addr = a; t.wr = wr;
    gq.push_back(t);
  endtask

  task automatic exp_rdv(input logic [2:0] oh, input logic [15:0] d);
    rdv_t t;
    t.oh = oh; t.data = d;
    rq.push_back(t);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  logic [15:0] rd_val [3];
`ifdef NPU_SRAM_ARB_BURST_EN
  localparam int SEQ_N = 6;
  int seq [SEQ_N] = '{1, 1, 1, 1, 2, 0};
`else
  localparam int SEQ_N = 4;
  int seq [SEQ_N] = '{1, 2, 0, 1};
`endif

  initial begin
    rd_val[0] = 16'h1111;
    rd_val[1] = 16'h2222;
    rd_val[2] = 16'h3333;
    reset = 1'b1;
    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_address    = '0;
    bus.req_writedata  = '0;
    bus.req_byteenable = '0;
`ifdef NPU_SRAM_ARB_BURST_EN
    bus.req_lock       = '0;
`endif
    // Requests pending during reset must not be granted.
    bus.req_read = 3'b111;
    repeat (2) cycle();
    @(negedge clk);
    check_eq("rst_waitreq", 32'(bus.req_waitrequest), 32'h7);
    check_eq("rst_cs", 32'(bus.sram_chipselect), 32'h0);
    check_eq("rst_write", 32'(bus.sram_write), 32'h0);
    check_eq("rst_rdv", 32'(bus.req_readdatavalid), 32'h0);
    check_eq("clken", 32'(bus.sram_clken), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_read = '0;
    cycle();

    // Single read by requester 1.
    set_slot(1, 12'h123, 16'h0, 2'b11);
    bus.req_read = 3'b010;
    exp_grant(1, 12'h123, 1'b0);
    exp_rdv(3'b010, 16'hBEEF);
    cycle();
    bus.req_read = '0;
    cycle();

    // Low-byte write by requester 2 (rr_ptr ends at 0).
    set_slot(2, 12'hFFF, 16'hA55A, 2'b01);
    bus.req_write = 3'b100;
    exp_grant(2, 12'hFFF, 1'b1);
    cycle();
    bus.req_write = '0;
    cycle();

    // Full contention: 0,1,2,0,1,2.
    for (int i = 0; i < 3; i++) set_slot(i, 12'h010 + 12'(i), 16'h0, 2'b11);
    for (int k = 0; k < 6; k++) begin
      exp_grant(k % 3, 12'h010 + 12'(k % 3), 1'b0);
      exp_rdv(3'b001 << (k % 3), rd_val[k % 3]);
    end
    bus.req_read = 3'b111;
    repeat (6) cycle();
    bus.req_read = '0;
    cycle();

    // Read back the byte-written word.
    set_slot(0, 12'hFFF, 16'h0, 2'b11);
    bus.req_read = 3'b001;
    exp_grant(0, 12'hFFF, 1'b0);
    exp_rdv(3'b001, 16'h125A);
    cycle();
    bus.req_read = '0;
    cycle();

    // Read and write together: write happens, no read data.
    set_slot(0, 12'h020, 16'h5678, 2'b11);
    bus.req_read  = 3'b001;
    bus.req_write = 3'b001;
    exp_grant(0, 12'h020, 1'b1);
    cycle();
    bus.req_read  = '0;
    bus.req_write = '0;
    repeat (2) cycle();
    bus.req_read = 3'b001;
    exp_grant(0, 12'h020, 1'b0);
    exp_rdv(3'b001, 16'h5678);
    cycle();
    bus.req_read = '0;
    cycle();

    // rr_ptr = 1 here; requester 1 asks for a lock (ignored without the burst feature).
    for (int i = 0; i < 3; i++) set_slot(i, 12'h010 + 12'(i), 16'h0, 2'b11);
    for (int k = 0; k < SEQ_N; k++) begin
      exp_grant(seq[k], 12'h010 + 12'(seq[k]), 1'b0);
      exp_rdv(3'b001 << seq[k], rd_val[seq[k]]);
    end
`ifdef NPU_SRAM_ARB_BURST_EN
    bus.req_lock = 3'b010;
`endif
    bus.req_read = 3'b111;
    repeat (SEQ_N) cycle();
    bus.req_read = '0;
`ifdef NPU_SRAM_ARB_BURST_EN
    bus.req_lock = '0;
`endif
    repeat (2) cycle();

    // Reset right after an accepted read: its data must never be flagged valid.
    set_slot(2, 12'h012, 16'h0, 2'b11);
    set_slot(1, 12'h011, 16'h0, 2'b11);
    bus.req_read = 3'b100;
    exp_grant(2, 12'h012, 1'b0);
    cycle();
    reset = 1'b1;
    bus.req_read = 3'b110;
    @(negedge clk);
    check_eq("midrst_rdv", 32'(bus.req_readdatavalid), 32'h0);
    check_eq("midrst_waitreq", 32'(bus.req_waitrequest), 32'h7);
    check_eq("midrst_cs", 32'(bus.sram_chipselect), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_grant(1, 12'h011, 1'b0);
    exp_rdv(3'b010, 16'h2222);
    cycle();
    bus.req_read = '0;
    repeat (3) cycle();

    check_eq("grant_queue_left", 32'(gq.size()), 32'h0);
    check_eq("rdv_queue_left", 32'(rq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_sram_arbiter.md
Name: npu_sram_arbiter

Overview:
- Shares one Avalon-MM port of the 4096 x 16-bit on-chip SRAM between NUM_REQ NPU masters (weight loader, activation engine, result writer).
- Performs round-robin arbitration, muxes each granted command onto the SRAM port, and returns read data to the correct requester.
- Sits between the NPU datapath and the SRAM s1 (or s2) port, in the SRAM clock domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 12, SRAM word address width.
- DATA_W, 16, SRAM data width; the byteenable width is DATA_W/8.
- MAX_BURST, 8, maximum consecutive grants held under lock. Used only with the optional feature.

Ports:
- clk  in  1  system clock. SRAM port and all requesters are on this clock.
- reset  in  1  synchronous, active-high reset.
- req_address  in  NUM_REQ*ADDR_W  per-requester word address; requester i uses slice i.
- req_read  in  NUM_REQ  per-requester read request.
- req_write  in  NUM_REQ  per-requester write request.
- req_writedata  in  NUM_REQ*DATA_W  per-requester write data.
- req_byteenable  in  NUM_REQ*2  per-requester byte enables.
- req_waitrequest  out  NUM_REQ  high means the command is not accepted this cycle.
- req_readdata  out  DATA_W  shared read-data return bus.
- req_readdatavalid  out  NUM_REQ  one-hot; marks req_readdata as valid for requester i.
- sram_address  out  ADDR_W  to SRAM address.
- sram_chipselect  out  1  to SRAM chipselect.
- sram_write  out  1  to SRAM write.
- sram_writedata  out  DATA_W  to SRAM writedata.
- sram_byteenable  out  2  to SRAM byteenable.
- sram_clken  out  1  to SRAM clken; tied to 1.
- sram_readdata  in  DATA_W  from SRAM readdata (unregistered q output).

Behaviour:
- Active request: requester i is active when req_read[i] | req_write[i].
- Grant selection: each cycle, combinationally grant the first active requester, searching from rr_ptr upward and wrapping from NUM_REQ-1 to 0.
  - At most one grant per cycle.
  - With no active requester there is no grant.
- Waitrequest: req_waitrequest[g] = 0 for the granted requester g; all others = 1. The command is accepted on the clock edge where waitrequest is 0.
- SRAM drive on a grant:
  - sram_chipselect = 1.
  - sram_write = req_write[g].
  - sram_address, sram_writedata and sram_byteenable are taken from slice g.
- SRAM drive with no grant: sram_chipselect = 0, sram_write = 0, sram_address = 0, sram_writedata = 0, sram_byteenable = 0.
- Read and write together: if req_read[g] and req_write[g] are both high, the write is performed and the read is dropped. This is a protocol error with no readdatavalid.
- Pointer update: on each accepted command, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Read latency: exactly 1 cycle.
  - Registered rd_pending (one-hot, NUM_REQ bits) is set from the accepted read.
  - req_readdatavalid = rd_pending.
  - req_readdata = sram_readdata (passthrough; valid in the cycle after acceptance).
- Throughput: back-to-back reads from different requesters sustain 1 access per cycle. A read in cycle N followed by a write in cycle N+1 is legal.
- Reset behaviour (synchronous, active-high):
  - While reset is high: all req_waitrequest = 1, sram_chipselect = 0, sram_write = 0, no grants.
  - Registers reset to: rr_ptr = 0, rd_pending = 0, burst_cnt = 0, locked = 0.
  - A read accepted in the cycle before reset asserts gets no readdatavalid; rd_pending is cleared.
- Holding: requesters must hold command signals stable while waitrequest is 1. The arbiter does not store rejected commands.

Optional Feature:
- Macro: NPU_SRAM_ARB_BURST_EN.
- Defined:
  - Adds input port req_lock (NUM_REQ).
  - If the granted requester g has req_lock[g] = 1 at acceptance, set locked = 1, lock_id = g, and increment burst_cnt.
  - While locked and req_lock[lock_id] = 1 and lock_id is active, lock_id is granted ahead of round-robin order.
  - Lock releases when req_lock[lock_id] drops, when lock_id is idle for a cycle, or when burst_cnt reaches MAX_BURST.
  - On release: rr_ptr <= (lock_id+1) mod NUM_REQ, burst_cnt = 0, locked = 0.
  - Reset clears the lock.
- Not defined: no req_lock port, no lock state; pure per-access round-robin.

Test Plan:
- Single read: after reset, req_read[1] = 1, addr 0x123 (SRAM preloaded 0x123 -> 0xBEEF) -> waitrequest[1] = 0 in cycle 0; readdatavalid = 3'b010 and readdata = 0xBEEF in cycle 1.
- Contention: all 3 requesters read continuously from rr_ptr = 0 -> grants 0,1,2,0,1,2; each readdatavalid one-hot arrives exactly 1 cycle after its grant.
- Byte write: req 2 writes 0xA55A, be = 2'b01, to 0x0FFF (old value 0x1234); then req 0 reads 0x0FFF -> readdata 0x125A.
- Read+write same requester: req 0 has read = write = 1 -> write occurs, no readdatavalid.
- Reset mid-read: read accepted in cycle N, reset high in N+1 -> readdatavalid stays 0; the next grant after reset goes to the lowest active index.
- With NPU_SRAM_ARB_BURST_EN, MAX_BURST = 4: req 1 locked and reading, req 0 and req 2 also requesting -> grants 1,1,1,1,2,0; without the macro -> grants 1,2,0,1,...
